cache_control: RTL and testbench

Sequencing FSM for the 2-way set-associative, write-back, write-allocate L1 cache built around two `data_array` instances (one per way), the tag/valid/dirty arrays and the LRU array. It accepts CPU read/write requests, consumes per-way hit and dirty status from the cache datapath, and drives the byte write masks, array load strobes and physical-memory handshake. It also keeps hit/miss performance counters.

---
 rtl/cache_control_if.sv | 28 ++
 rtl/cache_control.sv | 140 ++++++++++++++
 tb/tb_cache_control.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_control_if.sv
// CPU request and physical-memory handshake bundle for the L1 cache controller.
// master: request/memory environment side; slave: the controller.
interface cache_control_if #(
  parameter int S_OFFSET = 5
);
  logic                  mem_read;
  logic                  mem_write;
  logic [3:0]            mem_byte_enable;
  logic [S_OFFSET-3:0]   word_sel;
  logic                  mem_resp;
  logic                  pmem_read;
  logic                  pmem_write;
  logic                  pmem_resp;

  modport master (
    output mem_read, mem_write,
    output mem_byte_enable, word_sel,
    output pmem_resp,
    input  mem_resp, pmem_read, pmem_write
  );

  modport slave (
    input  mem_read, mem_write,
    input  mem_byte_enable, word_sel,
    input  pmem_resp,
    output mem_resp, pmem_read, pmem_write
  );
endinterface

// File: rtl/cache_control.sv
// Sequencing FSM for a 2-way write-back, write-allocate L1 cache,
// with hit/miss performance counters.
module cache_control #(
  parameter int s_offset = 5,
  parameter int s_mask   = 2**s_offset
) (
  input  logic              clk,
  input  logic              rst,
  cache_control_if.slave    bus,
  input  logic [1:0]        hit,
  input  logic [1:0]        dirty,
  input  logic              lru,
  output logic              pmem_addr_sel,
  output logic [s_mask-1:0] way0_write_en,
  output logic [s_mask-1:0] way1_write_en,
  output logic              datain_sel,
  output logic [1:0]        tag_load,
  output logic [1:0]        valid_load,
  output logic [1:0]        dirty_load,
  output logic              dirty_in,
  output logic              lru_load,
  output logic              lru_in,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);

  typedef enum logic [1:0] {
    IDLE, CHECK, WRITEBACK, FILL
  } state_t;

  state_t            r_state;
  state_t            w_state_n;
  logic              r_victim;
  logic              r_miss;
  logic [31:0]       r_hit_count;
  logic [31:0]       r_miss_count;
  logic              w_req;
  logic              w_hway;
  logic              w_miss;
  logic              w_resp;
  logic              w_pread;
  logic              w_pwrite;
  logic [s_mask-1:0] w_be_line;

  assign w_req  = bus.mem_read | bus.mem_write;
  // way 0 wins when both ways report a hit
  assign w_hway = ~hit[0];
  assign w_be_line =
    {{(s_mask-4){1'b0}}, bus.mem_byte_enable}
      << {bus.word_sel, 2'b00};

  assign bus.mem_resp   = w_resp;
  assign bus.pmem_read  = w_pread;
  assign bus.pmem_write = w_pwrite;
  assign hit_count      = r_hit_count;
  assign miss_count     = r_miss_count;

  always_comb begin
    w_state_n     = r_state;
    w_miss        = 1'b0;
    w_resp        = 1'b0;
    w_pread       = 1'b0;
    w_pwrite      = 1'b0;
    pmem_addr_sel = 1'b0;
    way0_write_en = '0;
    way1_write_en = '0;
    datain_sel    = 1'b0;
    tag_load      = 2'b00;
    valid_load    = 2'b00;
    dirty_load    = 2'b00;
    dirty_in      = 1'b0;
    lru_load      = 1'b0;
    lru_in        = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_req) w_state_n = CHECK;
      end
      CHECK: begin
        if (!w_req) begin
          w_state_n = IDLE;
        end else if (|hit) begin
          w_resp    = 1'b1;
          lru_load  = 1'b1;
          lru_in    = ~w_hway;
          w_state_n = IDLE;
          if (bus.mem_write) begin
            if (w_hway) way1_write_en = w_be_line;
            else        way0_write_en = w_be_line;
            dirty_load[w_hway] = 1'b1;
            dirty_in           = 1'b1;
          end
        end else begin
          w_miss    = 1'b1;
          w_state_n = dirty[lru] ? WRITEBACK : FILL;
        end
      end
      WRITEBACK: begin
        w_pwrite      = 1'b1;
        pmem_addr_sel = 1'b1;
        if (bus.pmem_resp) w_state_n = FILL;
      end
      FILL: begin
        w_pread = 1'b1;
        if (bus.pmem_resp) begin
          if (r_victim) way1_write_en = '1;
          else          way0_write_en = '1;
          datain_sel           = 1'b1;
          tag_load[r_victim]   = 1'b1;
          valid_load[r_victim] = 1'b1;
          dirty_load[r_victim] = 1'b1;
          w_state_n            = CHECK;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_victim     <= 1'b0;
      r_miss       <= 1'b0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      r_state <= w_state_n;
      if (w_miss) begin
        r_victim     <= lru;
        r_miss       <= 1'b1;
        r_miss_count <= r_miss_count + 32'd1;
      end
      // only requests that never missed count as hits
      if (w_resp) begin
        r_miss <= 1'b0;
        if (!r_miss) r_hit_count <= r_hit_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_cache_control.sv
// Scoreboard bench for cache_control: directed cycles push expected
// output snapshots; a negedge monitor pops one per active DUT cycle.
module tb_cache_control;
  localparam int SO = 5;
  localparam int SM = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    hit, dirty;
  logic          lru;
  logic          pas;
  logic [SM-1:0] w0, w1;
  logic          dsel;
  logic [1:0]    tl, vl, dl;
  logic          din, ll, li;
  logic [31:0]   hc, mc;

  int total = 0;
  int bad   = 0;

  cache_control_if #(.S_OFFSET(SO)) bus ();

  cache_control #(.s_offset(SO), .s_mask(SM)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus.slave),
    .hit           (hit),
    .dirty         (dirty),
    .lru           (lru),
    .pmem_addr_sel (pas),
    .way0_write_en (w0),
    .way1_write_en (w1),
    .datain_sel    (dsel),
    .tag_load      (tl),
    .valid_load    (vl),
    .dirty_load    (dl),
    .dirty_in      (din),
    .lru_load      (ll),
    .lru_in        (li),
    .hit_count     (hc),
    .miss_count    (mc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        resp, prd, pwr, pas;
    logic [31:0] w0, w1;
    logic        ds;
    logic [1:0]  tl, vl, dl;
    logic        di, ll, li;
    logic [31:0] hc, mc;
  } obs_t;

  obs_t  cur;
  obs_t  eq[$];
  string nq[$];

  always_comb begin
    cur      = '0;
    cur.resp = bus.mem_resp;
    cur.prd  = bus.pmem_read;
    cur.pwr  = bus.pmem_write;
    cur.pas  = pas;
    cur.w0   = w0;
    cur.w1   = w1;
    cur.ds   = dsel;
    cur.tl   = tl;
    cur.vl   = vl;
    cur.dl   = dl;
    cur.di   = din;
    cur.ll   = ll;
    cur.li   = li;
    cur.hc   = hc;
    cur.mc   = mc;
  end

  function automatic obs_t z(input logic [31:0] h, input logic [31:0] m);
    obs_t o;
    o    = '0;
    o.hc = h;
    o.mc = m;
    return o;
  endfunction

  function automatic logic act(input obs_t o);
    return |{o.resp, o.prd, o.pwr, o.pas, o.w0, o.w1, o.ds,
             o.tl, o.vl, o.dl, o.di, o.ll, o.li};
  endfunction

  // monitor: one comparison per cycle in which the DUT drives anything
  always @(negedge clk) begin
    obs_t  e;
    string n;
    if (act(cur) === 1'b1) begin
      total++;
      if (eq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output: got %h want none", cur);
      end else begin
        e = eq.pop_front();
        n = nq.pop_front();
        if (cur !== e) begin
          bad++;
          $display("FAIL %s: got %h want %h", n, cur, e);
        end
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, got, want);
    end
  endtask

  task automatic cyc(input logic r, input logic w,
                     input logic [3:0] be, input logic [2:0] ws,
                     input logic [1:0] h, input logic [1:0] d,
                     input logic l, input logic pr,
                     input bit a, input obs_t e, input string n);
    bus.mem_read        = r;
    bus.mem_write       = w;
    bus.mem_byte_enable = be;
    bus.word_sel        = ws;
    bus.pmem_resp       = pr;
    hit                 = h;
    dirty               = d;
    lru                 = l;
    if (a) begin
      eq.push_back(e);
      nq.push_back(n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 4'h0, 3'd0, 2'b00, 2'b00, 0, 0, 0, '0, "");
  endtask

  obs_t e;

  initial begin
    rst = 1'b1;
    bus.mem_read = 0; bus.mem_write = 0;
    bus.mem_byte_enable = 0; bus.word_sel = 0;
    bus.pmem_resp = 0;
    hit = 0; dirty = 0; lru = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_outputs", 32'(act(cur)), 0);
    chk("reset_hit_count", hc, 0);
    chk("reset_miss_count", mc, 0);

    // read hit on way 1
    cyc(1, 0, 4'h0, 3'd0, 2'b10, 2'b00, 0, 0, 0, '0, "");
    e = z(0, 0); e.resp = 1; e.ll = 1; e.li = 0;
    cyc(1, 0, 4'h0, 3'd0, 2'b10, 2'b00, 0, 0, 1, e, "read_hit");
    idle();
    chk("read_hit_count", hc, 1);

    // write hit on way 0, word 3, bytes 1-2
    cyc(0, 1, 4'b0110, 3'd3, 2'b01, 2'b00, 0, 0, 0, '0, "");
    e = z(1, 0); e.resp = 1; e.ll = 1; e.li = 1;
    e.w0 = 32'h0000_6000; e.dl = 2'b01; e.di = 1;
    cyc(0, 1, 4'b0110, 3'd3, 2'b01, 2'b00, 0, 0, 1, e, "write_hit");
    idle();
    chk("write_hit_count", hc, 2);

    // clean miss, victim way 1
    cyc(1, 0, 4'h0, 3'd0, 2'b00, 2'b01, 1, 0, 0, '0, "");
    cyc(1, 0, 4'h0, 3'd0, 2'b00, 2'b01, 1, 0, 0, '0, "");
    e = z(2, 1); e.prd = 1;
    for (int i = 0; i < 4; i++)
      cyc(1, 0, 4'h0, 3'd0, 2'b00, 2'b01, 1, 0, 1, e, "clean_fill_wait");
    e.w1 = '1; e.ds = 1; e.tl = 2'b10; e.vl = 2'b10; e.dl = 2'b10;
    cyc(1, 0, 4'h0, 3'd0, 2'b00, 2'b01, 1, 1, 1, e, "clean_fill_write");
    e = z(2, 1); e.resp = 1; e.ll = 1; e.li = 0;
    cyc(1, 0, 4'h0, 3'd0, 2'b10, 2'b01, 1, 0, 1, e, "clean_miss_resp");
    idle();
    chk("clean_miss_hits", hc, 2);
    chk("clean_miss_misses", mc, 1);

    // dirty miss, victim way 0 held while lru toggles
    cyc(0, 1, 4'hF, 3'd0, 2'b00, 2'b01, 0, 0, 0, '0, "");
    cyc(0, 1, 4'hF, 3'd0, 2'b00, 2'b01, 0, 0, 0, '0, "");
    e = z(2, 2); e.pwr = 1; e.pas = 1;
    cyc(0, 1, 4'hF, 3'd0, 2'b00, 2'b01, 0, 0, 1, e, "dirty_wb");
    cyc(0, 1, 4'hF, 3'd0, 2'b00, 2'b01, 1, 0, 1, e, "dirty_wb_lru1");
    cyc(0, 1, 4'hF, 3'd0, 2'b00, 2'b01, 1, 1, 1, e, "dirty_wb_done");
    e = z(2, 2); e.prd = 1;
    cyc(0, 1, 4'hF, 3'd0, 2'b00, 2'b01, 1, 0, 1, e, "dirty_fill");
    e.w0 = '1; e.ds = 1; e.tl = 2'b01; e.vl = 2'b01; e.dl = 2'b01;
    cyc(0, 1, 4'hF, 3'd0, 2'b00, 2'b01, 1, 1, 1, e, "dirty_fill_write");
    e = z(2, 2); e.resp = 1; e.ll = 1; e.li = 1;
    e.w0 = 32'h0000_000F; e.dl = 2'b01; e.di = 1;
    cyc(0, 1, 4'hF, 3'd0, 2'b01, 2'b01, 1, 0, 1, e, "dirty_miss_resp");
    idle();
    chk("dirty_miss_hits", hc, 2);
    chk("dirty_miss_misses", mc, 2);

    // pmem_resp while idle does nothing
    cyc(0, 0, 4'h0, 3'd0, 2'b00, 2'b00, 0, 1, 0, '0, "");
    chk("stray_pmem_resp", 32'(act(cur)), 0);

    // counter wrap with a dual-way write hit
    force dut.r_hit_count = 32'hFFFF_FFFF;
    idle();
    release dut.r_hit_count;
    idle();
    chk("forced_hit_count", hc, 32'hFFFF_FFFF);
    cyc(0, 1, 4'b0001, 3'd7, 2'b11, 2'b00, 0, 0, 0, '0, "");
    e = z(32'hFFFF_FFFF, 2); e.resp = 1; e.ll = 1; e.li = 1;
    e.w0 = 32'h1000_0000; e.dl = 2'b01; e.di = 1;
    cyc(0, 1, 4'b0001, 3'd7, 2'b11, 2'b00, 0, 0, 1, e, "dual_hit");
    idle();
    chk("hit_count_wrap", hc, 0);

    // reset mid-fill
    cyc(1, 0, 4'h0, 3'd0, 2'b00, 2'b00, 0, 0, 0, '0, "");
    cyc(1, 0, 4'h0, 3'd0, 2'b00, 2'b00, 0, 0, 0, '0, "");
    e = z(0, 3); e.prd = 1;
    cyc(1, 0, 4'h0, 3'd0, 2'b00, 2'b00, 0, 0, 1, e, "pre_reset_fill");
    rst = 1'b1;
    cyc(1, 0, 4'h0, 3'd0, 2'b00, 2'b00, 0, 0, 1, e, "reset_cycle_fill");
    rst = 1'b0;
    chk("midfill_reset_outputs", 32'(act(cur)), 0);
    chk("midfill_reset_hits", hc, 0);
    chk("midfill_reset_misses", mc, 0);
    bus.mem_read = 0;
    cyc(1, 0, 4'h0, 3'd0, 2'b01, 2'b00, 0, 0, 0, '0, "");
    e = z(0, 0); e.resp = 1; e.ll = 1; e.li = 1;
    cyc(1, 0, 4'h0, 3'd0, 2'b01, 2'b00, 0, 0, 1, e, "post_reset_hit");
    idle();
    chk("post_reset_hit_count", hc, 1);

    idle();
    chk("scoreboard_drained", eq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
